// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues {src, dst} register-transfer requests and
// sequences each as a DRIVE cycle followed by a LOAD cycle on the shared bus,
// emitting one-hot drive (source) and load (destination) enables.
module bus_transfer_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_src,
    input  logic [4:0]  req_dst,
    output logic [23:0] drive_en,
    output logic [31:0] load_en,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    cur_src_q, cur_src_d;
    logic [4:0]    cur_dst_q, cur_dst_d;
    logic [23:0]   drive_en_q, drive_en_d;
    logic [31:0]   load_en_q, load_en_d;
    logic          xfer_done_q, xfer_done_d;
    logic          xfer_err_q, xfer_err_d;

    logic          push;
    logic          pop;
    logic [4:0]    head_src;
    logic [4:0]    head_dst;
    logic          head_ok;

    // Source must exist on the bus encoder, destination must be a loadable register.
    function automatic logic req_is_valid(input logic [4:0] src, input logic [4:0] dst);
        logic dst_ok;
        dst_ok = (dst <= 5'd17) || (dst == 5'd20) || (dst == 5'd21) ||
                 ((dst >= 5'd24) && (dst <= 5'd27));
        return (src <= 5'd23) && dst_ok;
    endfunction

    assign req_ready = (count_q < DEPTH_C);
    assign push      = req_valid && req_ready;
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign head_src  = mem_q[rd_ptr_q][9:5];
    assign head_dst  = mem_q[rd_ptr_q][4:0];
    assign head_ok   = req_is_valid(head_src, head_dst);

    assign drive_en  = drive_en_q;
    assign load_en   = load_en_q;
    assign xfer_done = xfer_done_q;
    assign xfer_err  = xfer_err_q;

    // Sequencer next state and next registered outputs; IDLE and LOAD share the pop path.
    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        drive_en_d  = '0;
        load_en_d   = '0;
        xfer_done_d = 1'b0;
        xfer_err_d  = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                state_d = IDLE;
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        state_d    = DRIVE;
                        cur_src_d  = head_src;
                        cur_dst_d  = head_dst;
                        drive_en_d = 24'd1 << head_src;
                    end else begin
                        xfer_err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                state_d     = LOAD;
                drive_en_d  = 24'd1 << cur_src_q;
                load_en_d   = 32'd1 << cur_dst_q;
                xfer_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage, pointer and occupancy updates.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {req_src, req_dst};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            drive_en_q  <= '0;
            load_en_q   <= '0;
            xfer_done_q <= 1'b0;
            xfer_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            drive_en_q  <= drive_en_d;
            load_en_q   <= load_en_d;
            xfer_done_q <= xfer_done_d;
            xfer_err_q  <= xfer_err_d;
        end
    end

    // FIFO payload storage; entries are qualified by count, so no clear needed.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Testbench for bus_transfer_sequencer: directed timing tasks plus a
// transaction-level scoreboard monitor that tracks accepted requests.
module tb_bus_transfer_sequencer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0] s;
        logic [4:0] d;
    } req_t;

    logic        clock;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic [23:0] drive_en;
    logic [31:0] load_en;
    logic        xfer_done;
    logic        xfer_err;
    logic        busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_err    = 0;
    bit   mon_en   = 0;
    bit   in_drive = 0;
    bit   saw_full = 0;
    req_t exp_q[$];

    bus_transfer_sequencer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .drive_en  (drive_en),
        .load_en   (load_en),
        .xfer_done (xfer_done),
        .xfer_err  (xfer_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Valid iff source code is 0..23 and destination bit is set in the loadable mask.
    function automatic bit model_valid(input req_t r);
        logic [31:0] mask;
        mask = 32'h0F33FFFF;
        return (r.s < 5'd24) && mask[r.d];
    endfunction

    // Scoreboard: every accepted request must show up in order as either
    // DRIVE then LOAD (valid) or a single xfer_err pulse (invalid).
    always @(negedge clock) begin : monitor
        bit   is_drive, is_load, is_err;
        int   occ;
        req_t f;
        if (mon_en) begin
            is_load  = in_drive;
            is_drive = !in_drive && (drive_en != '0);
            is_err   = !in_drive && (drive_en == '0) && xfer_err;
            occ = exp_q.size() - ((is_load || is_drive || is_err) ? 1 : 0);
            if (occ < 0) occ = 0;

            n_checks++;
            if (($countones(drive_en) > 1) || ($countones(load_en) > 1)) begin
                n_fail++;
                $display("FAIL onehot: drive_en=%h load_en=%h required at most one bit each", drive_en, load_en);
            end
            n_checks++;
            if (req_ready !== (occ < DEPTH)) begin
                n_fail++;
                $display("FAIL req_ready: got %b required %b (fifo occupancy %0d)", req_ready, (occ < DEPTH), occ);
            end
            n_checks++;
            if (busy !== ((occ != 0) || is_drive || is_load)) begin
                n_fail++;
                $display("FAIL busy: got %b required %b", busy, ((occ != 0) || is_drive || is_load));
            end

            if (is_load) begin
                f = exp_q[0];
                n_checks++;
                if ((drive_en !== (24'd1 << f.s)) || (load_en !== (32'd1 << f.d)) ||
                    (xfer_done !== 1'b1) || (xfer_err !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL load_phase: got drive=%h load=%h done=%b err=%b required drive=%h load=%h done=1 err=0",
                             drive_en, load_en, xfer_done, xfer_err, 24'd1 << f.s, 32'd1 << f.d);
                end
                void'(exp_q.pop_front());
                in_drive = 0;
                n_done++;
            end else if (is_drive) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_drive: got drive_en=%h required 0 with no request pending", drive_en);
                end else begin
                    f = exp_q[0];
                    if (!model_valid(f) || (drive_en !== (24'd1 << f.s)) ||
                        (load_en !== '0) || (xfer_done !== 1'b0)) begin
                        n_fail++;
                        $display("FAIL drive_phase: got drive=%h load=%h done=%b required drive=%h load=0 done=0 (req valid=%0d)",
                                 drive_en, load_en, xfer_done, 24'd1 << f.s, model_valid(f));
                    end
                end
                in_drive = 1;
            end else if (is_err) begin
                n_checks++;
                if ((exp_q.size() == 0) || model_valid(exp_q[0]) || (load_en !== '0) || (xfer_done !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL err_pulse: got err=1 load=%h done=%b required an invalid request at queue head (queued=%0d)",
                             load_en, xfer_done, exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_err++;
            end else begin
                n_checks++;
                if ((load_en !== '0) || (xfer_done !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL idle_quiet: got load=%h done=%b required 0 and 0", load_en, xfer_done);
                end
            end

            if (clear) begin
                exp_q.delete();
                in_drive = 0;
            end else if (req_valid && req_ready) begin
                exp_q.push_back('{s: req_src, d: req_dst});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic push_req(input logic [4:0] s, input logic [4:0] d);
        bit accepted;
        accepted  = 0;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (req_ready) accepted = 1;
            else saw_full = 1;
            step();
        end
        req_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL push_timeout: got no accept for src=%0d dst=%0d required accept within 200 cycles", s, d);
        end
    endtask

    task automatic drain(input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            step();
            if ((exp_q.size() == 0) && !in_drive && !busy) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: got busy=%b queued=%0d required idle within %0d cycles", busy, exp_q.size(), maxc);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req_valid = 1'b0;
        req_src = '0;
        req_dst = '0;
        step();
        step();
        n_checks++;
        if ((drive_en !== '0) || (load_en !== '0)) begin
            n_fail++;
            $display("FAIL reset_enables: got drive=%h load=%h required 0 0", drive_en, load_en);
        end
        n_checks++;
        if ((xfer_done !== 1'b0) || (xfer_err !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_pulses: got done=%b err=%b required 0 0", xfer_done, xfer_err);
        end
        n_checks++;
        if ((req_ready !== 1'b1) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_status: got ready=%b busy=%b required 1 0", req_ready, busy);
        end
        clear = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_single();
        push_req(5'd3, 5'd7);
        n_checks++;
        if ((drive_en !== '0) || (busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL single_c0: got drive=%h busy=%b required 0 1", drive_en, busy);
        end
        step();
        n_checks++;
        if ((drive_en !== 24'h000008) || (load_en !== '0) || (xfer_done !== 1'b0)) begin
            n_fail++;
            $display("FAIL single_drive: got drive=%h load=%h done=%b required 000008 0 0", drive_en, load_en, xfer_done);
        end
        step();
        n_checks++;
        if ((drive_en !== 24'h000008) || (load_en !== 32'h00000080) || (xfer_done !== 1'b1)) begin
            n_fail++;
            $display("FAIL single_load: got drive=%h load=%h done=%b required 000008 00000080 1", drive_en, load_en, xfer_done);
        end
        step();
        n_checks++;
        if ((drive_en !== '0) || (load_en !== '0) || (xfer_done !== 1'b0) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL single_end: got drive=%h load=%h done=%b busy=%b required all 0", drive_en, load_en, xfer_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        push_req(5'd20, 5'd24);
        push_req(5'd21, 5'd25);
        n_checks++;
        if ((drive_en !== (24'd1 << 20)) || (load_en !== '0)) begin
            n_fail++;
            $display("FAIL b2b_drive1: got drive=%h load=%h required %h 0", drive_en, load_en, 24'd1 << 20);
        end
        step();
        n_checks++;
        if ((drive_en !== (24'd1 << 20)) || (load_en !== (32'd1 << 24)) || (xfer_done !== 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_load1: got drive=%h load=%h done=%b", drive_en, load_en, xfer_done);
        end
        step();
        n_checks++;
        if ((drive_en !== (24'd1 << 21)) || (load_en !== '0) || (xfer_done !== 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_drive2: got drive=%h load=%h done=%b required %h 0 0", drive_en, load_en, xfer_done, 24'd1 << 21);
        end
        step();
        n_checks++;
        if ((drive_en !== (24'd1 << 21)) || (load_en !== (32'd1 << 25)) || (xfer_done !== 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_load2: got drive=%h load=%h done=%b", drive_en, load_en, xfer_done);
        end
        step();
        n_checks++;
        if ((drive_en !== '0) || (load_en !== '0) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_end: got drive=%h load=%h busy=%b required 0 0 0", drive_en, load_en, busy);
        end
    endtask

    task automatic test_invalid();
        int e0;
        e0 = n_err;
        push_req(5'd25, 5'd1);
        push_req(5'd1, 5'd19);
        n_checks++;
        if ((xfer_err !== 1'b1) || (drive_en !== '0) || (load_en !== '0)) begin
            n_fail++;
            $display("FAIL invalid_err1: got err=%b drive=%h load=%h required 1 0 0", xfer_err, drive_en, load_en);
        end
        step();
        n_checks++;
        if ((xfer_err !== 1'b1) || (drive_en !== '0) || (load_en !== '0)) begin
            n_fail++;
            $display("FAIL invalid_err2: got err=%b drive=%h load=%h required 1 0 0", xfer_err, drive_en, load_en);
        end
        step();
        n_checks++;
        if ((xfer_err !== 1'b0) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL invalid_end: got err=%b busy=%b required 0 0", xfer_err, busy);
        end
        n_checks++;
        if ((n_err - e0) != 2) begin
            n_fail++;
            $display("FAIL invalid_count: got %0d error pulses required 2", n_err - e0);
        end
    endtask

    task automatic test_fill();
        int d0;
        d0 = n_done;
        saw_full = 0;
        for (int i = 0; i < 8; i++) begin
            push_req(5'($urandom_range(0, 15)), 5'($urandom_range(0, 17)));
        end
        n_checks++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL fill_full: got req_ready never low required low once %0d entries queued", DEPTH);
        end
        drain(100);
        n_checks++;
        if ((n_done - d0) != 8) begin
            n_fail++;
            $display("FAIL fill_count: got %0d transfers required 8", n_done - d0);
        end
    endtask

    task automatic test_clear();
        push_req(5'd0, 5'd1);
        push_req(5'd2, 5'd16);
        push_req(5'd3, 5'd4);
        push_req(5'd5, 5'd6);
        n_checks++;
        if (drive_en !== (24'd1 << 2)) begin
            n_fail++;
            $display("FAIL clear_pre: got drive=%h required %h", drive_en, 24'd1 << 2);
        end
        clear = 1'b1;
        req_valid = 1'b1;
        req_src = 5'd7;
        req_dst = 5'd7;
        step();
        clear = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if ((drive_en !== '0) || (load_en !== '0) || (busy !== 1'b0) || (req_ready !== 1'b1)) begin
            n_fail++;
            $display("FAIL clear_after: got drive=%h load=%h busy=%b ready=%b required 0 0 0 1", drive_en, load_en, busy, req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if ((drive_en !== '0) || (load_en !== '0) || (busy !== 1'b0)) begin
                n_fail++;
                $display("FAIL clear_quiet: got drive=%h load=%h busy=%b required all 0", drive_en, load_en, busy);
            end
        end
    endtask

    task automatic test_wrap();
        int   d0, e0;
        req_t r;
        d0 = n_done;
        e0 = n_err;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) step();
            r.s = 5'($urandom_range(0, 23));
            do r.d = 5'($urandom_range(0, 31)); while (!model_valid(r));
            if ((r.s <= 5'd17) && ($urandom_range(0, 3) == 0)) r.d = r.s;
            push_req(r.s, r.d);
        end
        drain(100);
        n_checks++;
        if (((n_done - d0) != 10) || ((n_err - e0) != 0)) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d done %0d err required 10 done 0 err", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_random_mix();
        int   d0, e0, nv, ni;
        req_t r;
        d0 = n_done;
        e0 = n_err;
        nv = 0;
        ni = 0;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) step();
            r.s = 5'($urandom_range(0, 31));
            r.d = 5'($urandom_range(0, 31));
            if (model_valid(r)) nv++;
            else ni++;
            push_req(r.s, r.d);
        end
        drain(150);
        n_checks++;
        if (((n_done - d0) != nv) || ((n_err - e0) != ni)) begin
            n_fail++;
            $display("FAIL mix_count: got %0d done %0d err required %0d done %0d err", n_done - d0, n_err - e0, nv, ni);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid();
        test_fill();
        test_clear();
        test_wrap();
        test_random_mix();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got simulation still running required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Queues register-transfer requests for the CPU's shared 32-bit bus and sequences each one as a two-phase drive/load operation. It decodes each 5-bit source code into the one-hot drive-enable vector that feeds the bus-source encoder, and each 5-bit destination code into a one-hot load-enable vector for the register file and special registers. It sits between the control unit and the datapath, so the control unit can post transfers without tracking bus timing.

## Interface
- DEPTH, 4: request FIFO entries; power of two, minimum 2.
- clock  in  1  rising-edge clock for all state.
- clear  in  1  synchronous active-high reset.
- req_valid  in  1  a transfer request is presented.
- req_ready  out  1  FIFO can accept a request; high when count < DEPTH.
- req_src  in  5  source code: 0–15 R0–R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C; 24–31 invalid.
- req_dst  in  5  destination code: 0–15 R0–R15, 16 HI, 17 LO, 20 PC, 21 MDR, 24 MAR, 25 IR, 26 Y, 27 OutPort; all other codes invalid.
- drive_en  out  24  one-hot source enables; bit n corresponds to source code n.
- load_en  out  32  one-hot destination enables; bit n corresponds to destination code n.
- xfer_done  out  1  one-cycle pulse, coincident with the load phase.
- xfer_err  out  1  one-cycle pulse when a popped request is invalid.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.

## Operation
- Handshake: a request is accepted at a rising edge when req_valid && req_ready. req_ready depends only on the registered count, so a push is never accepted while the FIFO is full, even if a pop happens in the same cycle.
- FIFO: DEPTH entries of {src, dst}, in-order, with pointers that wrap modulo DEPTH. Push and pop may occur in the same edge; count then stays unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head. If the popped request is valid, go to DRIVE; otherwise stay in IDLE and pulse xfer_err.
  - DRIVE: drive_en[src] = 1; load_en = 0. Next state is LOAD.
  - LOAD: drive_en[src] = 1; load_en[dst] = 1; xfer_done = 1. If the FIFO is non-empty, pop the head and go directly to DRIVE (valid request) or IDLE with xfer_err (invalid request). Otherwise go to IDLE.
- Validity: a request is valid only if src ≤ 23 and dst is in {0–17, 20, 21, 24–27}. An invalid request produces no enables at all and is discarded.
- At most one drive_en bit and at most one load_en bit may be high in any cycle. Both vectors are all-zero in IDLE.
- src == dst (for example R5→R5) is legal and sequenced normally.
- All outputs except req_ready and busy are registered.
- clear:
  - Next state: state = IDLE, FIFO empty, drive_en = 0, load_en = 0, xfer_done = 0, xfer_err = 0.
  - As a result, req_ready = 1 and busy = 0.
  - clear overrides any push in the same cycle and aborts any in-flight transfer. No load_en is asserted after clear.

## Timing
- Request accepted at edge N with the FIFO empty and the FSM in IDLE:
  - pop at edge N+1;
  - DRIVE in cycle N+1→N+2;
  - LOAD and xfer_done in cycle N+2→N+3;
  - back in IDLE at edge N+3.
- The destination captures the bus at the end of the LOAD cycle, i.e. edge N+3.
- Back-to-back transfers: one every 2 cycles, with no IDLE cycle between consecutive valid requests.
- Invalid request popped at edge P: xfer_err is high in cycle P→P+1. The next request, if present, is popped at edge P+1.
- busy falls in the cycle after the last LOAD cycle, provided no request is queued.

## Test plan
- Single transfer: push {src=3, dst=7} at edge 0 → drive_en = 0x000008 in cycles 1–2; load_en = 0x00000080 and xfer_done in cycle 2 only; all outputs zero in cycle 3.
- Special registers: PC→MAR, i.e. {20, 24} → drive_en bit 20, then load_en bit 24. Then MDR→IR, i.e. {21, 25}, issued back-to-back → second DRIVE immediately follows the first LOAD; total 4 cycles.
- Fill/full: push 5 requests on consecutive edges with DEPTH = 4 → req_ready low after the 4th accept; the 5th request is held until a pop; all 5 requests complete in order; a push attempted while full is never lost or duplicated.
- Invalid codes: push {src=25, dst=1}, then {src=1, dst=19} → two xfer_err pulses, no drive_en or load_en activity, busy then low.
- Clear mid-operation: assert clear during the DRIVE cycle of {2, 16} with 2 entries still queued → next cycle all enables are 0, busy = 0, req_ready = 1; no load_en[16] ever appears and the queued entries never execute.
- Wrap-around: 10 sequential valid transfers through DEPTH = 4 with random push gaps → in-order completion, exactly one-hot enables, and 10 xfer_done pulses.
